gyro_direction_detect: RTL and testbench



---
 rtl/gyro_direction_detect_pkg.sv | 17 +
 rtl/gyro_direction_detect_if.sv | 33 +++
 rtl/gyro_axis_classifier.sv | 88 ++++++++
 rtl/gyro_direction_detect.sv | 89 ++++++++
 tb/tb_gyro_direction_detect.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/gyro_direction_detect_pkg.sv
// Shared types and default constants for the gyro direction detector.
// Imported by the interface, the axis classifier and the top level.
package gyro_dir_pkg;

  typedef enum logic [1:0] {
    AX_NEUTRAL = 2'd0,
    AX_POS     = 2'd1,
    AX_NEG     = 2'd2
  } axis_state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_TH_ON     = 1000;
  localparam int DEF_TH_OFF    = 600;
  localparam int DEF_PERSIST   = 3;
  localparam int DEF_STALE_CYC = 1000;

endpackage

// File: rtl/gyro_direction_detect_if.sv
// Sample strobe and rate inputs plus direction flag outputs.
// master drives samples, slave is the detector.
interface gyro_direction_detect_if
  import gyro_dir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic                     sample_valid;
  logic signed [DATA_W-1:0] rate_x;
  logic signed [DATA_W-1:0] rate_y;
  logic signed [DATA_W-1:0] rate_z;
  logic                     gyroX;
  logic                     gyro_X;
  logic                     gyroY;
  logic                     gyro_Y;
  logic                     gyroZ;
  logic                     gyro_Z;
  logic                     flags_valid;
  logic                     gyro_stale;

  modport master (
    output sample_valid, rate_x, rate_y, rate_z,
    input  gyroX, gyro_X, gyroY, gyro_Y, gyroZ, gyro_Z,
    input  flags_valid, gyro_stale
  );

  modport slave (
    input  sample_valid, rate_x, rate_y, rate_z,
    output gyroX, gyro_X, gyroY, gyro_Y, gyroZ, gyro_Z,
    output flags_valid, gyro_stale
  );

endinterface

// File: rtl/gyro_axis_classifier.sv
// One axis: hysteresis thresholds plus persistence counting.
// All compares are signed against constants, never negating the input.
module gyro_axis_classifier
  import gyro_dir_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TH_ON   = DEF_TH_ON,
  parameter int TH_OFF  = DEF_TH_OFF,
  parameter int PERSIST = DEF_PERSIST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_force_neutral,
  input  logic                     i_upd,
  input  logic signed [DATA_W-1:0] i_rate,
  output axis_state_t              o_state
);
  localparam int CW = $clog2(PERSIST + 1);
  localparam logic signed [DATA_W-1:0] C_ON_P  = DATA_W'(TH_ON);
  localparam logic signed [DATA_W-1:0] C_ON_N  = DATA_W'(-TH_ON);
  localparam logic signed [DATA_W-1:0] C_OFF_P = DATA_W'(TH_OFF);
  localparam logic signed [DATA_W-1:0] C_OFF_N = DATA_W'(-TH_OFF);
  localparam logic [CW-1:0] C_P   = CW'(PERSIST);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  axis_state_t r_state;
  logic [CW-1:0] r_pos;
  logic [CW-1:0] r_neg;
  logic [CW-1:0] w_pos_inc;
  logic [CW-1:0] w_neg_inc;
  logic w_ge_on;
  logic w_le_non;
  logic w_lt_off;
  logic w_gt_noff;

  assign w_ge_on   = i_rate >= C_ON_P;
  assign w_le_non  = i_rate <= C_ON_N;
  assign w_lt_off  = i_rate <  C_OFF_P;
  assign w_gt_noff = i_rate >  C_OFF_N;
  assign w_pos_inc = (r_pos == C_P) ? r_pos : r_pos + C_ONE;
  assign w_neg_inc = (r_neg == C_P) ? r_neg : r_neg + C_ONE;
  assign o_state   = r_state;

  always_ff @(posedge clk) begin
    if (reset || i_force_neutral) begin
      r_state <= AX_NEUTRAL;
      r_pos   <= '0;
      r_neg   <= '0;
    end else if (i_upd) begin
      r_pos <= '0;
      r_neg <= '0;
      unique case (r_state)
        AX_NEUTRAL: begin
          if (w_ge_on) begin
            if (w_pos_inc == C_P) r_state <= AX_POS;
            else                  r_pos   <= w_pos_inc;
          end else if (w_le_non) begin
            if (w_neg_inc == C_P) r_state <= AX_NEG;
            else                  r_neg   <= w_neg_inc;
          end
        end
        AX_POS: begin
          // a hard swing counts as the first opposite sample
          if (w_lt_off) begin
            if (w_le_non && PERSIST == 1) begin
              r_state <= AX_NEG;
            end else begin
              r_state <= AX_NEUTRAL;
              if (w_le_non) r_neg <= C_ONE;
            end
          end
        end
        AX_NEG: begin
          if (w_gt_noff) begin
            if (w_ge_on && PERSIST == 1) begin
              r_state <= AX_POS;
            end else begin
              r_state <= AX_NEUTRAL;
              if (w_ge_on) r_pos <= C_ONE;
            end
          end
        end
        default: r_state <= AX_NEUTRAL;
      endcase
    end
  end

endmodule

// File: rtl/gyro_direction_detect.sv
// Gyro rate samples to six direction flags for the motor-control FSM.
// Stage 1 registers the sample, stage 2 classifies; a stale timer clears all.
module gyro_direction_detect
  import gyro_dir_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TH_ON     = DEF_TH_ON,
  parameter int TH_OFF    = DEF_TH_OFF,
  parameter int PERSIST   = DEF_PERSIST,
  parameter int STALE_CYC = DEF_STALE_CYC
) (
  input logic              clk,
  input logic              reset,
  gyro_direction_detect_if.slave bus
);
  localparam int TW = $clog2(STALE_CYC + 1);
  localparam logic [TW-1:0] C_T_MAX = TW'(STALE_CYC);
  localparam logic [TW-1:0] C_T_EXP = TW'(STALE_CYC - 1);

  logic                     r_s1_valid;
  logic signed [DATA_W-1:0] r_s1_x;
  logic signed [DATA_W-1:0] r_s1_y;
  logic signed [DATA_W-1:0] r_s1_z;
  logic [TW-1:0]            r_timer;
  logic                     r_stale;
  logic                     r_flags_valid;
  logic                     w_expire;
  axis_state_t              w_st_x;
  axis_state_t              w_st_y;
  axis_state_t              w_st_z;

  // a strobe landing in the expiry cycle keeps the data fresh
  assign w_expire = !bus.sample_valid && (r_timer == C_T_EXP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_x        <= '0;
      r_s1_y        <= '0;
      r_s1_z        <= '0;
      r_timer       <= '0;
      r_stale       <= 1'b0;
      r_flags_valid <= 1'b0;
    end else begin
      r_s1_valid    <= bus.sample_valid;
      r_flags_valid <= r_s1_valid;
      if (bus.sample_valid) begin
        r_s1_x <= bus.rate_x;
        r_s1_y <= bus.rate_y;
        r_s1_z <= bus.rate_z;
      end
      if (bus.sample_valid)      r_timer <= '0;
      else if (r_timer != C_T_MAX) r_timer <= r_timer + TW'(1);
      if (w_expire)        r_stale <= 1'b1;
      else if (r_s1_valid) r_stale <= 1'b0;
    end
  end

  gyro_axis_classifier #(
    .DATA_W(DATA_W), .TH_ON(TH_ON), .TH_OFF(TH_OFF), .PERSIST(PERSIST)
  ) u_ax_x (
    .clk(clk), .reset(reset), .i_force_neutral(w_expire),
    .i_upd(r_s1_valid), .i_rate(r_s1_x), .o_state(w_st_x)
  );

  gyro_axis_classifier #(
    .DATA_W(DATA_W), .TH_ON(TH_ON), .TH_OFF(TH_OFF), .PERSIST(PERSIST)
  ) u_ax_y (
    .clk(clk), .reset(reset), .i_force_neutral(w_expire),
    .i_upd(r_s1_valid), .i_rate(r_s1_y), .o_state(w_st_y)
  );

  gyro_axis_classifier #(
    .DATA_W(DATA_W), .TH_ON(TH_ON), .TH_OFF(TH_OFF), .PERSIST(PERSIST)
  ) u_ax_z (
    .clk(clk), .reset(reset), .i_force_neutral(w_expire),
    .i_upd(r_s1_valid), .i_rate(r_s1_z), .o_state(w_st_z)
  );

  assign bus.gyroX       = (w_st_x == AX_POS);
  assign bus.gyro_X      = (w_st_x == AX_NEG);
  assign bus.gyroY       = (w_st_y == AX_POS);
  assign bus.gyro_Y      = (w_st_y == AX_NEG);
  assign bus.gyroZ       = (w_st_z == AX_POS);
  assign bus.gyro_Z      = (w_st_z == AX_NEG);
  assign bus.flags_valid = r_flags_valid;
  assign bus.gyro_stale  = r_stale;

endmodule

// File: tb/tb_gyro_direction_detect.sv
// Scoreboard bench: directed plan sequences then random rates and gaps,
// checked against a tilt/streak reference model.
module tb_gyro_direction_detect;
  localparam int DW = 16;
  localparam int ON = 1000;
  localparam int OFF = 600;
  localparam int P = 3;
  localparam int ST = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  gyro_direction_detect_if #(.DATA_W(DW)) bus ();

  gyro_direction_detect #(
    .DATA_W(DW), .TH_ON(ON), .TH_OFF(OFF), .PERSIST(P), .STALE_CYC(ST)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // tilt: +1/0/-1 ; streak: signed run length of strong samples
  int tilt[3];
  int streak[3];
  logic [5:0] q[$];
  logic [5:0] disp;
  logic [5:0] pend_flags;
  bit pend;
  bit exp_stale;
  bit started;
  int gap;
  int last[3];

  function automatic void model_axis(int a, int r);
    if (tilt[a] == 1) begin
      streak[a] = 0;
      if (r < OFF) begin
        tilt[a] = 0;
        if (r <= -ON) streak[a] = -1;
      end
    end else if (tilt[a] == -1) begin
      streak[a] = 0;
      if (r > -OFF) begin
        tilt[a] = 0;
        if (r >= ON) streak[a] = 1;
      end
    end else begin
      if (r >= ON) streak[a] = (streak[a] > 0) ? streak[a] + 1 : 1;
      else if (r <= -ON) streak[a] = (streak[a] < 0) ? streak[a] - 1 : -1;
      else streak[a] = 0;
    end
    if (streak[a] >= P) begin tilt[a] = 1; streak[a] = 0; end
    if (streak[a] <= -P) begin tilt[a] = -1; streak[a] = 0; end
  endfunction

  function automatic logic [5:0] model_flags();
    logic [5:0] f;
    f = {tilt[0] == 1, tilt[0] == -1, tilt[1] == 1,
         tilt[1] == -1, tilt[2] == 1, tilt[2] == -1};
    return f;
  endfunction

  function automatic void model_clear();
    for (int a = 0; a < 3; a++) begin
      tilt[a] = 0;
      streak[a] = 0;
    end
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      model_clear();
      q.delete();
      pend = 1'b0;
      disp = '0;
      gap = 0;
      exp_stale = 1'b0;
    end else begin
      if (pend) begin
        disp = pend_flags;
        exp_stale = 1'b0;
      end
      pend = bus.sample_valid;
      if (bus.sample_valid) begin
        gap = 0;
        model_axis(0, int'(bus.rate_x));
        model_axis(1, int'(bus.rate_y));
        model_axis(2, int'(bus.rate_z));
        pend_flags = model_flags();
        q.push_back(pend_flags);
      end else if (gap < ST) begin
        gap++;
        if (gap == ST) begin
          exp_stale = 1'b1;
          disp = '0;
          model_clear();
        end
      end
    end
  end

  task automatic chk(string n, logic [5:0] got, logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", n, got, exp, $time);
    end
  endtask

  logic [5:0] w_flags;
  assign w_flags = {bus.gyroX, bus.gyro_X, bus.gyroY,
                    bus.gyro_Y, bus.gyroZ, bus.gyro_Z};

  always @(negedge clk) begin
    if (started) begin
      chk("flags_level", w_flags, disp);
      chk("stale", {5'd0, bus.gyro_stale}, {5'd0, exp_stale});
      chk("excl", {3'd0, bus.gyroX & bus.gyro_X,
                   bus.gyroY & bus.gyro_Y, bus.gyroZ & bus.gyro_Z}, 6'd0);
      if (bus.flags_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_flags_valid got=1 exp=0 t=%0t", $time);
        end else begin
          chk("sample", w_flags, q.pop_front());
        end
      end
    end
  end

  task automatic drive(bit v, int x, int y, int z);
    @(negedge clk);
    bus.sample_valid = v;
    bus.rate_x = DW'(x);
    bus.rate_y = DW'(y);
    bus.rate_z = DW'(z);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  function automatic int pick(int a);
    int v;
    if ($urandom_range(0, 1) == 0) return last[a];
    case ($urandom_range(0, 11))
      0: v = 1000;
      1: v = 999;
      2: v = 600;
      3: v = 599;
      4: v = -1000;
      5: v = -999;
      6: v = -600;
      7: v = -599;
      8: v = -32768;
      9: v = 32767;
      10: v = ($urandom_range(0, 1) == 0) ? 1200 : -1200;
      default: v = int'($urandom_range(0, 65535)) - 32768;
    endcase
    last[a] = v;
    return v;
  endfunction

  initial begin
    bus.sample_valid = 1'b0;
    bus.rate_x = '0;
    bus.rate_y = '0;
    bus.rate_z = '0;
    for (int a = 0; a < 3; a++) last[a] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    repeat (3) drive(1, 1200, 0, 0);
    drive(1, 700, 0, 0);
    drive(1, 599, 0, 0);
    repeat (3) drive(1, 1200, 0, 0);
    repeat (3) drive(1, -32768, 0, 0);
    idle(2);

    for (int i = 0; i < 10; i++) drive(1, 0, (i % 2 == 0) ? 1200 : 500, 0);
    idle(2);

    repeat (3) drive(1, 0, 0, 1200);
    idle(70);
    drive(1, 0, 0, 0);
    idle(3);

    repeat (3) drive(1, 0, -1200, 1200);
    idle(ST - 1);
    drive(1, 0, -1200, 1200);
    idle(3);

    repeat (3) drive(1, 1200, 1200, 1200);
    idle(2);
    drive(1, 1200, 1200, 1200);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r >= 95) idle(int'($urandom_range(ST - 4, ST + 4)));
      else if (r >= 70) idle(int'($urandom_range(1, 4)));
      drive(1, pick(0), pick(1), pick(2));
    end
    idle(5);
    chk("queue_empty", 6'(q.size()), 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
